// File: rtl/filtered_fifo_pkg.sv
// ----------------------------------------------------------------------------
// filtered_fifo_pkg
//   Shared types, constants and helpers for the filtered-FIFO write-port
//   arbiter.
//   - STAT_WIDTH   : width of each per-producer accepted-lane counter
//   - req_id_t     : producer index type (default configuration)
//   - lane_count_t : per-beat kept-lane count type (default configuration)
//   - arb_state_e  : arbiter FSM states
//   - popcount()   : number of set bits in a keep mask (up to 64 lanes)
// ----------------------------------------------------------------------------
package filtered_fifo_pkg;

    localparam int STAT_WIDTH      = 16;
    localparam int NUM_REQ_DEF     = 4;
    localparam int MAX_INPUTS_DEF  = 4;
    localparam int POP_MAX_LANES   = 64;

    typedef logic [$clog2(NUM_REQ_DEF)-1:0]      req_id_t;
    // Needs MAX_INPUTS+1 codes so that an all-lanes-kept beat does not wrap.
    typedef logic [$clog2(MAX_INPUTS_DEF+1)-1:0] lane_count_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Counts set bits of a keep mask zero-extended to POP_MAX_LANES bits.
    // The result holds 0..64; callers cast it to their own lane-count width.
    function automatic logic [7:0] popcount(input logic [POP_MAX_LANES-1:0] mask);
        logic [7:0] cnt;
        cnt = '0;
        for (int i = 0; i < POP_MAX_LANES; i++) begin
            cnt = cnt + {7'b0, mask[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/filtered_fifo_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin pick: returns the first asserted request at or
//   after rr_ptr, wrapping modulo NUM_REQ. Holds no state.
//   Ports:
//     req     in  NUM_REQ  request vector
//     rr_ptr  in  ID_W     highest-priority index for this pick
//     found   out 1        at least one request asserted
//     idx     out ID_W     index of the winner (0 when none)
//     onehot  out NUM_REQ  one-hot form of the winner (0 when none)
// ----------------------------------------------------------------------------
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx,
    output logic [NUM_REQ-1:0] onehot
);

    always_comb begin
        int cand;
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        cand   = 0;
        // Scan NUM_REQ positions starting at rr_ptr; the first hit wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req[cand]) begin
                found        = 1'b1;
                idx          = cand[ID_W-1:0];
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/filtered_fifo_arbiter.sv
// ----------------------------------------------------------------------------
// filtered_fifo_arbiter
//   Shares one filtered-FIFO write port among NUM_REQ producers. Round-robin
//   grant with packet lock: a producer whose non-last beat is accepted keeps
//   the port until its req_last beat is accepted. A one-beat registered
//   output stage drives the FIFO input handshake.
//
//   Optional feature macro: FILTERED_FIFO_ARB_STATS_EN
//     defined     -> per-producer saturating counters of accepted kept lanes
//     not defined -> stat_count tied to zero, no counter flops
//
//   Ports:
//     clk, rst     clock; synchronous active-high reset
//     req_valid    producer beat valid            [NUM_REQ]
//     req_data     producer lanes                 [NUM_REQ][MAX_INPUTS]
//     req_keep     producer lane keep masks       [NUM_REQ][MAX_INPUTS]
//     req_last     last beat of producer packet   [NUM_REQ]
//     req_ready    beat accepted when valid&&ready (at most one high)
//     ds_valid     registered beat valid to the filtered FIFO
//     ds_data      registered lanes
//     ds_keep      registered keep (never all-zero while ds_valid)
//     ds_ready     filtered FIFO in_ready
//     grant_id     current / last granted producer
//     locked       packet lock held
//     stat_count   accepted-lane counters          [NUM_REQ][16]
// ----------------------------------------------------------------------------
module filtered_fifo_arbiter
    import filtered_fifo_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  BIT_WIDTH  = 32,
    parameter int  MAX_INPUTS = 4,
    parameter type DATA_TYPE  = logic [BIT_WIDTH-1:0],
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic     [NUM_REQ-1:0]                   req_valid,
    input  DATA_TYPE [NUM_REQ-1:0][MAX_INPUTS-1:0]   req_data,
    input  logic     [NUM_REQ-1:0][MAX_INPUTS-1:0]   req_keep,
    input  logic     [NUM_REQ-1:0]                   req_last,
    output logic     [NUM_REQ-1:0]                   req_ready,
    output logic                                     ds_valid,
    output DATA_TYPE [MAX_INPUTS-1:0]                ds_data,
    output logic     [MAX_INPUTS-1:0]                ds_keep,
    input  logic                                     ds_ready,
    output logic     [ID_W-1:0]                      grant_id,
    output logic                                     locked,
    output logic     [NUM_REQ-1:0][STAT_WIDTH-1:0]   stat_count
);

    localparam int LC_W = $clog2(MAX_INPUTS + 1);

    arb_state_e                  state_q, state_d;
    logic     [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic     [ID_W-1:0]         grant_id_q, grant_id_d;
    logic                        ds_valid_q, ds_valid_d;
    DATA_TYPE [MAX_INPUTS-1:0]   ds_data_q, ds_data_d;
    logic     [MAX_INPUTS-1:0]   ds_keep_q, ds_keep_d;

    logic                        pick_found;
    logic     [ID_W-1:0]         pick_idx;
    logic     [NUM_REQ-1:0]      pick_onehot;

    logic                        can_load;
    logic     [ID_W-1:0]         sel_idx;
    logic                        sel_valid;
    logic                        accept;

    // Wrap-around increment of a producer index.
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        if (int'(id) == NUM_REQ - 1) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_picker (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // ------------------------------------------------------------------
    // Next-state / handshake logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        ds_valid_d = ds_valid_q;
        ds_data_d  = ds_data_q;
        ds_keep_d  = ds_keep_q;
        req_ready  = '0;

        // The output register can take a beat when empty or draining now.
        can_load = !ds_valid_q || ds_ready;

        if (state_q == ARB_IDLE) begin
            sel_idx   = pick_idx;
            sel_valid = pick_found;
        end else begin
            // While locked, only the lock holder is considered.
            sel_idx   = grant_id_q;
            sel_valid = req_valid[grant_id_q];
        end

        // No beat is taken during reset: it would be lost to the reset.
        accept = can_load && sel_valid && !rst;

        if (accept) begin
            if (state_q == ARB_IDLE) begin
                req_ready = pick_onehot;
            end else begin
                req_ready[grant_id_q] = 1'b1;
            end
            grant_id_d = sel_idx;

            unique case (state_q)
                ARB_IDLE: begin
                    rr_ptr_d = next_id(sel_idx);
                    if (!req_last[sel_idx]) begin
                        state_d = ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (req_last[sel_idx]) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = next_id(grant_id_q);
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end

        // A beat with no kept lanes is consumed but never presented
        // downstream; the register still drains if the FIFO took it.
        if (accept && (|req_keep[sel_idx])) begin
            ds_valid_d = 1'b1;
            ds_data_d  = req_data[sel_idx];
            ds_keep_d  = req_keep[sel_idx];
        end else if (ds_ready) begin
            ds_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            ds_valid_q <= 1'b0;
            ds_data_q  <= '0;
            ds_keep_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            ds_valid_q <= ds_valid_d;
            ds_data_q  <= ds_data_d;
            ds_keep_q  <= ds_keep_d;
        end
    end

    assign ds_valid = ds_valid_q;
    assign ds_data  = ds_data_q;
    assign ds_keep  = ds_keep_q;
    assign grant_id = grant_id_q;
    assign locked   = (state_q == ARB_LOCKED);

    // ------------------------------------------------------------------
    // Accepted-lane statistics
    // ------------------------------------------------------------------
`ifdef FILTERED_FIFO_ARB_STATS_EN
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_stat
            logic [LC_W-1:0]         lane_cnt;
            logic [STAT_WIDTH:0]     stat_sum;
            logic [STAT_WIDTH-1:0]   stat_q, stat_d;

            assign lane_cnt = LC_W'(popcount(POP_MAX_LANES'(req_keep[gi])));
            // One extra bit catches the carry so the counter can saturate.
            assign stat_sum = {1'b0, stat_q} + (STAT_WIDTH+1)'(lane_cnt);

            always_comb begin
                stat_d = stat_q;
                if (req_ready[gi]) begin
                    stat_d = stat_sum[STAT_WIDTH] ? '1 : stat_sum[STAT_WIDTH-1:0];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    stat_q <= '0;
                end else begin
                    stat_q <= stat_d;
                end
            end

            assign stat_count[gi] = stat_q;
        end
    endgenerate
`else
    assign stat_count = '0;
`endif

endmodule
